// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requesting agents (master) and the arbiter (slave).
// The lock vector is present only when ARB_LOCK_EN is defined.
interface rr_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]         request;
  logic [N-1:0]         grant;
  logic                 grant_valid;
  logic [$clog2(N)-1:0] grant_id;
`ifdef ARB_LOCK_EN
  logic [N-1:0]         lock;

  modport master (output request, output lock, input grant, input grant_valid, input grant_id);
  modport slave  (input request, input lock, output grant, output grant_valid, output grant_id);
`else
  modport master (output request, input grant, input grant_valid, input grant_id);
  modport slave  (input request, output grant, output grant_valid, output grant_id);
`endif
endinterface

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter with a per-grant hold quantum and zero-bubble handoff.
// Optional feature macro ARB_LOCK_EN: an owner with its lock bit set is exempt from the quantum.
module rr_arbiter #(
  parameter int N       = 4,
  parameter int QUANTUM = 8
) (
  input logic         clk,
  input logic         rst_n,
  rr_arbiter_if.slave arb
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(QUANTUM + 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] last_ptr_q, last_ptr_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic          valid_q, valid_d;

  logic [N-1:0]  others;
  logic [IW:0]   pick_all, pick_oth;
  logic          owner_req, owner_lock, quantum_hit;
  logic          take;
  logic [IW-1:0] take_idx;

  // Returns {found, index} of the first set bit scanning ptr+1, ptr+2, ... modulo N.
  function automatic logic [IW:0] pick(input logic [N-1:0] req, input logic [IW-1:0] ptr);
    logic          found;
    logic [IW-1:0] idx;
    int            j;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned (no latches).
    state_d    = state_q;
    last_ptr_d = last_ptr_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    valid_d    = valid_q;
    take       = 1'b0;
    take_idx   = '0;

    others    = arb.request & ~grant_q;
    pick_all  = pick(arb.request, last_ptr_q);
    pick_oth  = pick(others, last_ptr_q);
    owner_req = arb.request[last_ptr_q];
`ifdef ARB_LOCK_EN
    owner_lock = arb.lock[last_ptr_q];
`else
    owner_lock = 1'b0;
`endif
    quantum_hit = (hold_cnt_q == CW'(QUANTUM)) && !owner_lock;

    case (state_q)
      IDLE: begin
        if (pick_all[IW]) begin
          take     = 1'b1;
          take_idx = pick_all[IW-1:0];
        end
      end
      BUSY: begin
        if (owner_req && !(quantum_hit && pick_oth[IW])) begin
          if (hold_cnt_q != CW'(QUANTUM)) hold_cnt_d = hold_cnt_q + CW'(1);
        end else if (pick_oth[IW]) begin
          // Owner excluded from the scan: covers both quantum expiry and owner drop.
          take     = 1'b1;
          take_idx = pick_oth[IW-1:0];
        end else begin
          state_d    = IDLE;
          hold_cnt_d = '0;
          grant_d    = '0;
          grant_id_d = '0;
          valid_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d           = BUSY;
      last_ptr_d        = take_idx;
      hold_cnt_d        = CW'(1);
      grant_d           = '0;
      grant_d[take_idx] = 1'b1;
      grant_id_d        = take_idx;
      valid_d           = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
    if (!rst_n) begin
      state_q    <= IDLE;
      last_ptr_q <= IW'(N - 1);
      hold_cnt_q <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_ptr_q <= last_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      valid_q    <= valid_d;
    end
  end

  assign arb.grant       = grant_q;
  assign arb.grant_valid = valid_q;
  assign arb.grant_id    = grant_id_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N=4, QUANTUM=8): vector table plus multi-cycle sequences.
// Lock sequence is compiled in only when ARB_LOCK_EN is defined.
module tb_rr_arbiter;
  localparam int N = 4;
  localparam int Q = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_arbiter_if #(.N(N)) arb ();

  rr_arbiter #(.N(N), .QUANTUM(Q)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (arb.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] g;
    logic       v;
    logic [1:0] id;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [3:0] g, input logic v, input logic [1:0] id);
    check({name, " grant"}, 32'(arb.grant), 32'(g));
    check({name, " valid"}, 32'(arb.grant_valid), 32'(v));
    check({name, " id"}, 32'(arb.grant_id), 32'(id));
    check({name, " onehot0"}, 32'($onehot0(arb.grant)), 32'd1);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    arb.request = '0;
`ifdef ARB_LOCK_EN
    arb.lock    = '0;
`endif
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [1:0] exp_id;
    rst_n       = 1'b0;
    arb.request = '0;
`ifdef ARB_LOCK_EN
    arb.lock    = '0;
`endif

    //           rst   req      grant    v     id
    vecs[0]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0};  // reset holds with all requesting
    vecs[1]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0};
    vecs[2]  = '{1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0};  // first grant from requester 0
    vecs[3]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0};  // owner drops, nobody else
    vecs[4]  = '{1'b1, 4'b0100, 4'b0100, 1'b1, 2'd2};
    vecs[5]  = '{1'b1, 4'b0110, 4'b0100, 1'b1, 2'd2};  // newcomer does not disturb owner
    vecs[6]  = '{1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1};  // drop + handoff, scan wraps 3,0,1
    vecs[7]  = '{1'b1, 4'b0101, 4'b0100, 1'b1, 2'd2};  // zero-bubble handoff 1 -> 2
    vecs[8]  = '{1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0};
    vecs[9]  = '{1'b0, 4'b1000, 4'b0000, 1'b0, 2'd0};  // reset beats request mid-grant
    vecs[10] = '{1'b1, 4'b1000, 4'b1000, 1'b1, 2'd3};
    vecs[11] = '{1'b0, 4'b1000, 4'b0000, 1'b0, 2'd0};
    vecs[12] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0};

    for (int i = 0; i < 13; i++) begin
      rst_n       = vecs[i].rst_n;
      arb.request = vecs[i].req;
      step();
      check_out($sformatf("vec%0d", i), vecs[i].g, vecs[i].v, vecs[i].id);
    end

    // Single requester held well past the quantum, then released.
    do_reset();
    arb.request = 4'b0100;
    for (int c = 0; c < 21; c++) begin
      step();
      check_out($sformatf("single c%0d", c), 4'b0100, 1'b1, 2'd2);
    end
    arb.request = 4'b0000;
    step();
    check_out("single drop", 4'b0000, 1'b0, 2'd0);

    // Two competitors: quantum rotation 0 -> 3 -> 0 with wrap.
    do_reset();
    arb.request = 4'b1001;
    for (int c = 0; c < 24; c++) begin
      step();
      exp_g  = ((c / Q) % 2 == 0) ? 4'b0001 : 4'b1000;
      exp_id = ((c / Q) % 2 == 0) ? 2'd0 : 2'd3;
      check_out($sformatf("wrap c%0d", c), exp_g, 1'b1, exp_id);
    end

    // All requesting: owners 0,1,2,3,0 each for exactly Q cycles.
    do_reset();
    arb.request = 4'b1111;
    for (int c = 0; c < 5 * Q; c++) begin
      step();
      exp_id = 2'((c / Q) % N);
      exp_g  = 4'b0001 << exp_id;
      check_out($sformatf("fair c%0d", c), exp_g, 1'b1, exp_id);
    end

`ifdef ARB_LOCK_EN
    // Locked owner ignores the quantum; rotation fires on the edge lock falls.
    do_reset();
    arb.request = 4'b0011;
    arb.lock    = 4'b0001;
    for (int c = 0; c < 30; c++) begin
      step();
      check_out($sformatf("lock c%0d", c), 4'b0001, 1'b1, 2'd0);
    end
    arb.lock = 4'b0000;
    step();
    check_out("lock release", 4'b0010, 1'b1, 2'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Registered round-robin arbiter that shares one resource between N requesters and drives a one-hot grant, the same request/grant contract the arbiter interface uses. It sits between the requesting agents and the shared resource. A grant is held for as long as its owner keeps requesting, up to a per-grant quantum. Ownership then rotates fairly to the next pending requester with no idle cycle between owners.

## Interface
- `N`, default 4: number of requesters; legal range 2..16.
- `QUANTUM`, default 8: maximum consecutive cycles an owner keeps the grant while others wait; must be ≥1.
- `clk` input 1: sole clock; all logic on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low. Sampled on the rising edge of `clk`.
- `request` input N: bit i high means requester i wants the resource. Level-sensitive.
- `grant` output N: one-hot or zero, registered. Bit i means requester i owns the resource.
- `grant_valid` output 1: equals the OR of `grant`, registered.
- `grant_id` output $clog2(N): index of the current owner; 0 when `grant_valid`=0.
- `lock` input N (present only with `ARB_LOCK_EN`): owner i with `lock[i]`=1 is exempt from the quantum.

## Operation
- States:
  - IDLE: no owner.
  - BUSY: exactly one owner.
- Internal registers:
  - `last_ptr` ($clog2(N) bits): last granted index.
  - `hold_cnt` ($clog2(QUANTUM+1) bits): grant-hold counter.
- Reset (`rst_n`=0 at an edge), applied regardless of current state:
  - `grant`=0, `grant_valid`=0, `grant_id`=0.
  - State returns to IDLE.
  - `last_ptr`=N-1, so requester 0 has first priority.
  - `hold_cnt`=0.
- Winner selection: the first requester with `request` set, scanning `last_ptr`+1, `last_ptr`+2, … modulo N. Wrap from N-1 to 0 is required.
- IDLE → BUSY: any `request` bit set. The winner is granted, `last_ptr`=winner, `hold_cnt`=1.
- BUSY, owner still requesting, and either `hold_cnt`<QUANTUM or no other requester pending:
  - Grant is held.
  - `hold_cnt` increments and saturates at QUANTUM.
- BUSY, owner still requesting, `hold_cnt`==QUANTUM, and another requester pending:
  - Rotate to the next winner, excluding the current owner.
  - `hold_cnt`=1.
- BUSY, owner drops `request`:
  - If another requester is pending, grant moves directly to the next winner on the same edge, and `hold_cnt`=1.
  - Otherwise go to IDLE with `grant`=0 and `hold_cnt`=0.
- Non-owner request changes never disturb the current owner except through the quantum rule.
- `grant` is never multi-hot.
- `grant` never goes to a requester whose `request` was 0 at the deciding edge.

## Timing
- Decisions use the `request` value sampled at a rising edge. `grant`, `grant_valid` and `grant_id` update at that same edge and are visible in the following cycle.
- Request-to-grant latency from IDLE: 1 cycle. Request high before edge k gives grant high after edge k.
- Release-to-regrant latency: 0 bubble cycles. The old owner's grant bit falls and the new owner's bit rises at the same edge.
- Owner drop: its `grant` bit is low after the edge at which the dropped request is sampled.
- Quantum: an owner keeps the grant for exactly QUANTUM cycles when a competitor is waiting throughout.
- Simultaneous events:
  - Owner drop plus new requests at the same edge: the new requests are eligible at that edge.
  - Reset plus requests at the same edge: reset wins.
- Reset mid-grant: outputs are 0 after that edge. The first grant after reset is taken from requester 0 upward.

## Configuration
- `ARB_LOCK_EN` defined:
  - The `lock` port exists.
  - While the owner's `lock` bit is 1, the quantum rule is suppressed and the owner keeps the grant until it drops `request`. `hold_cnt` still saturates.
  - When `lock` falls, the quantum rule resumes. A saturated `hold_cnt` triggers rotation at the next edge if another requester is pending.
- `ARB_LOCK_EN` undefined:
  - No `lock` port.
  - The quantum always applies.

## Test plan
- Reset sanity: `rst_n`=0 for 2 cycles with `request`=4'b1111 -> `grant`=0, `grant_valid`=0, `grant_id`=0 throughout. First edge after release -> `grant`=4'b0001.
- Single requester: `request`=4'b0100 -> `grant`=4'b0100 and `grant_id`=2 after one edge. Held for 20 cycles with no rotation. Drop request -> `grant`=0 next edge.
- Rotation with wrap: `request`=4'b1001, owner 0, QUANTUM=8 -> after 8 cycles `grant`=4'b1000. After 8 more cycles `grant`=4'b0001.
- Zero-bubble handoff: owner 1 drops while `request`=4'b0101 -> same edge `grant`=4'b0100. `grant_valid` never 0.
- Fairness: `request`=4'b1111 held constant -> grant order 0,1,2,3,0, each owner for 8 cycles. Never multi-hot.
- Lock (`ARB_LOCK_EN` defined): owner 0 with `lock`=4'b0001, `request`=4'b0011 -> owner 0 keeps the grant for 30 cycles. Lock drops -> `grant`=4'b0010 after the next edge.
